histogram_sequencer: RTL

//  Drives histogram_wrapper's direct-control ports (WISHBONE_INTERFACE_EN=0) for autonomous in-FPGA runs.
//  Per run: clear, configure, acquire for a programmed window, read all bins into an AXI-Stream FIFO.

---
 rtl/histogram_seq_pkg.sv | 24 ++
 rtl/histogram_sequencer_if.sv | 12 +
 rtl/histogram_seq_fifo.sv | 47 ++++
 rtl/histogram_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/histogram_seq_pkg.sv
// Shared types for the histogram sequencer: FSM states and the per-start configuration snapshot.
package histogram_seq_pkg;

  localparam int unsigned CHANNEL_W = 6;
  localparam int unsigned SHIFT_W   = 5;
  localparam int unsigned ACQ_W     = 32;
  localparam int unsigned RUNS_W    = 16;

  typedef enum logic [2:0] {IDLE, CLEAR, CONFIG, ACQUIRE, READ, FLUSH} state_t;

  typedef struct packed {
    logic [CHANNEL_W-1:0] click;
    logic [CHANNEL_W-1:0] start;
    logic [SHIFT_W-1:0]   shift;
    logic [ACQ_W-1:0]     acq_last;
    logic [RUNS_W-1:0]    runs;
  } cfg_t;

  // Terminal count of the acquisition window; a zero window behaves as one cycle.
  function automatic logic [ACQ_W-1:0] acq_last_of(input logic [ACQ_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - ACQ_W'(1);
  endfunction

endpackage

// File: rtl/histogram_sequencer_if.sv
// AXI-Stream style bin stream carrying histogram words and an end-of-run marker.
interface histogram_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/histogram_seq_fifo.sv
// First-word-fall-through synchronous FIFO; a push is accepted when full if a pop happens alongside.
module histogram_seq_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Head is forced to zero when empty so the stream outputs read 0 out of reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/histogram_sequencer.sv
// Autonomous run controller for histogram_wrapper: clear, configure, acquire, then stream all bins out.
module histogram_sequencer
  import histogram_seq_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = CHANNEL_W,
  parameter int unsigned SHIFT_WIDTH   = SHIFT_W,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_BINS      = 4096,
  parameter int unsigned CLEAR_CYCLES  = 4096,
  parameter int unsigned ACQ_WIDTH     = ACQ_W,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [CHANNEL_WIDTH-1:0] cfg_click_i,
  input  logic [CHANNEL_WIDTH-1:0] cfg_start_i,
  input  logic [SHIFT_WIDTH-1:0]   cfg_shift_i,
  input  logic [ACQ_WIDTH-1:0]     cfg_acq_cycles_i,
  input  logic [RUNS_W-1:0]        cfg_runs_i,
  output logic                     hist_reset_o,
  output logic                     config_en_o,
  output logic [CHANNEL_WIDTH-1:0] click_channel_o,
  output logic [CHANNEL_WIDTH-1:0] start_channel_o,
  output logic [SHIFT_WIDTH-1:0]   shift_val_o,
  output logic                     hist_read_o,
  input  logic [DATA_WIDTH-1:0]    hist_data_i,
  input  logic                     hist_valid_i,
  histogram_sequencer_if.master    m_axis,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [RUNS_W-1:0]        run_count_o,
  output logic                     overflow_o
);
  localparam int unsigned BIN_W = $clog2(NUM_BINS);
  localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int unsigned CNT_W = (ACQ_WIDTH > CLR_W) ? ACQ_WIDTH : CLR_W;

  state_t             state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [RUNS_W-1:0]  run_q, run_d;
  logic               ovf_q, ovf_d;
  logic               hist_reset_d, config_en_d, hist_read_d, busy_d, done_d;

  logic               beat, last_beat, drop;
  logic               fifo_full, fifo_empty;
  logic [DATA_WIDTH:0] fifo_rdata;

  // Bins are only accepted while reading; counting continues through drops to keep framing.
  assign beat      = hist_valid_i && ((state_q == READ) || (state_q == FLUSH));
  assign last_beat = beat && (bin_q == BIN_W'(NUM_BINS - 1));
  assign drop      = beat && fifo_full && !(m_axis.tready && !fifo_empty);

  histogram_seq_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (beat),
    .wdata ({last_beat, hist_data_i}),
    .full  (fifo_full),
    .pop   (m_axis.tready),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tlast  = fifo_rdata[DATA_WIDTH];
  assign m_axis.tdata  = fifo_rdata[DATA_WIDTH-1:0];

  assign click_channel_o = CHANNEL_WIDTH'(cfg_q.click);
  assign start_channel_o = CHANNEL_WIDTH'(cfg_q.start);
  assign shift_val_o     = SHIFT_WIDTH'(cfg_q.shift);
  assign run_count_o     = run_q;
  assign overflow_o      = ovf_q;

  // Next-state logic; single-cycle strobes are computed on the transition and registered.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    cnt_d        = cnt_q;
    bin_d        = bin_q;
    run_d        = run_q;
    ovf_d        = ovf_q;
    hist_reset_d = 1'b0;
    config_en_d  = 1'b0;
    hist_read_d  = 1'b0;
    done_d       = 1'b0;

    if (beat) begin
      bin_d = last_beat ? '0 : bin_q + BIN_W'(1);
      if (drop) ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          cfg_d.click    = CHANNEL_W'(cfg_click_i);
          cfg_d.start    = CHANNEL_W'(cfg_start_i);
          cfg_d.shift    = SHIFT_W'(cfg_shift_i);
          cfg_d.acq_last = acq_last_of(ACQ_W'(cfg_acq_cycles_i));
          cfg_d.runs     = cfg_runs_i;
          run_d          = '0;
          ovf_d          = 1'b0;
          cnt_d          = '0;
          bin_d          = '0;
          hist_reset_d   = 1'b1;
          state_d        = CLEAR;
        end
      end
      CLEAR: begin
        if (abort_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          cnt_d       = '0;
          config_en_d = 1'b1;
          state_d     = CONFIG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONFIG: begin
        if (abort_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (abort_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(cfg_q.acq_last)) begin
          bin_d       = '0;
          hist_read_d = 1'b1;
          state_d     = READ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        if (last_beat) begin
          run_d = run_q + RUNS_W'(1);
          if (!abort_i && ((cfg_q.runs == '0) || (run_d < cfg_q.runs))) begin
            cnt_d        = '0;
            hist_reset_d = 1'b1;
            state_d      = CLEAR;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (abort_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      cnt_q        <= '0;
      bin_q        <= '0;
      run_q        <= '0;
      ovf_q        <= 1'b0;
      hist_reset_o <= 1'b0;
      config_en_o  <= 1'b0;
      hist_read_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      cnt_q        <= cnt_d;
      bin_q        <= bin_d;
      run_q        <= run_d;
      ovf_q        <= ovf_d;
      hist_reset_o <= hist_reset_d;
      config_en_o  <= config_en_d;
      hist_read_o  <= hist_read_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
    end
  end

endmodule
